// File: rtl/duty_breathe_if.sv
// Control and duty bundle between the button/switch front end and duty_breathe.
// The master side drives the requests; the slave side returns duty, frame tick and state.
interface duty_breathe_if;
   logic       en;
   logic       mode;
   logic       inc;
   logic       dec;
   logic [7:0] duty;
   logic       frame_tick;
   logic [1:0] state;

   modport master (
      output en, mode, inc, dec,
      input  duty, frame_tick, state
   );

   modport slave (
      input  en, mode, inc, dec,
      output duty, frame_tick, state
   );
endinterface

// File: rtl/duty_breathe.sv
// Frame-aligned duty source for the LED PWM stage.
// Produces either a breathing ramp or a manually stepped level.
module duty_breathe #(
   parameter int PERIOD_CYCLES   = 100000,
   parameter int FRAMES_PER_STEP = 4,
   parameter int STEP            = 1,
   parameter int HOLD_FRAMES     = 50,
   parameter int MAN_STEP        = 16
) (
   input logic           clk,
   input logic           rst,
   duty_breathe_if.slave bus
);

   typedef enum logic [1:0] {
      RISE    = 2'd0,
      HOLD_HI = 2'd1,
      FALL    = 2'd2,
      HOLD_LO = 2'd3
   } state_t;

   localparam int MAX_FRAMES = (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
   localparam int CW         = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES);
   localparam int PW         = (PERIOD_CYCLES < 2) ? 1 : $clog2(PERIOD_CYCLES);

   localparam logic [PW-1:0] LAST_CYCLE = PW'(PERIOD_CYCLES - 1);
   localparam logic [CW-1:0] STEP_LAST  = CW'(FRAMES_PER_STEP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_FRAMES - 1);
   localparam logic [8:0]    STEP9      = 9'(STEP);
   localparam logic [8:0]    MAN9       = 9'(MAN_STEP);

   logic [PW-1:0] cycle_cnt;
   logic [PW-1:0] cycle_next;
   logic          tick_q;
   logic [7:0]    duty_q,   duty_d;
   state_t        state_q,  state_d;
   logic [CW-1:0] frames_q, frames_d;
   logic          pend_inc_q, pend_inc_d;
   logic          pend_dec_q, pend_dec_d;
   logic          seen_manual_q, seen_manual_d;
   logic          update;
   logic [8:0]    ramp_up;
   logic [8:0]    man_up;

   assign cycle_next = (cycle_cnt == LAST_CYCLE) ? '0 : cycle_cnt + 1'b1;
   assign update     = tick_q & bus.en;
   assign ramp_up    = {1'b0, duty_q} + STEP9;
   assign man_up     = {1'b0, duty_q} + MAN9;

   // Tick is registered from the next count so it is high exactly while the count is at the last cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt <= '0;
         tick_q    <= 1'b0;
      end else begin
         cycle_cnt <= cycle_next;
         tick_q    <= (cycle_next == LAST_CYCLE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         duty_q        <= 8'd0;
         state_q       <= RISE;
         frames_q      <= '0;
         pend_inc_q    <= 1'b0;
         pend_dec_q    <= 1'b0;
         seen_manual_q <= 1'b0;
      end else begin
         duty_q        <= duty_d;
         state_q       <= state_d;
         frames_q      <= frames_d;
         pend_inc_q    <= pend_inc_d;
         pend_dec_q    <= pend_dec_d;
         seen_manual_q <= seen_manual_d;
      end
   end

   // A visit to manual mode makes the next breathing update re-enter RISE from the current duty.
   always_comb begin
      duty_d        = duty_q;
      state_d       = state_q;
      frames_d      = frames_q;
      seen_manual_d = seen_manual_q | ~bus.mode;

      if (update && bus.mode) begin
         if (seen_manual_q) begin
            state_d       = RISE;
            frames_d      = '0;
            seen_manual_d = 1'b0;
         end else begin
            case (state_q)
               RISE: begin
                  if (frames_q == STEP_LAST) begin
                     frames_d = '0;
                     if (ramp_up >= 9'd255) begin
                        duty_d  = 8'd255;
                        state_d = HOLD_HI;
                     end else begin
                        duty_d = ramp_up[7:0];
                     end
                  end else begin
                     frames_d = frames_q + 1'b1;
                  end
               end
               HOLD_HI: begin
                  if (frames_q == HOLD_LAST) begin
                     frames_d = '0;
                     state_d  = FALL;
                  end else begin
                     frames_d = frames_q + 1'b1;
                  end
               end
               FALL: begin
                  if (frames_q == STEP_LAST) begin
                     frames_d = '0;
                     if ({1'b0, duty_q} <= STEP9) begin
                        duty_d  = 8'd0;
                        state_d = HOLD_LO;
                     end else begin
                        duty_d = duty_q - STEP9[7:0];
                     end
                  end else begin
                     frames_d = frames_q + 1'b1;
                  end
               end
               HOLD_LO: begin
                  if (frames_q == HOLD_LAST) begin
                     frames_d = '0;
                     state_d  = RISE;
                  end else begin
                     frames_d = frames_q + 1'b1;
                  end
               end
            endcase
         end
      end else if (update) begin
         if (pend_inc_q && !pend_dec_q) begin
            duty_d = (man_up >= 9'd255) ? 8'd255 : man_up[7:0];
         end else if (pend_dec_q && !pend_inc_q) begin
            duty_d = ({1'b0, duty_q} > MAN9) ? duty_q - MAN9[7:0] : 8'd0;
         end
      end
   end

   // Requests arriving on the update edge start the next frame's pending set.
   always_comb begin
      pend_inc_d = pend_inc_q | bus.inc;
      pend_dec_d = pend_dec_q | bus.dec;
      if (bus.mode) begin
         pend_inc_d = 1'b0;
         pend_dec_d = 1'b0;
      end else if (update) begin
         pend_inc_d = bus.inc;
         pend_dec_d = bus.dec;
      end
   end

   assign bus.duty       = duty_q;
   assign bus.frame_tick = tick_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_duty_breathe.sv
// Randomized and directed bench for duty_breathe against a frame-level reference model.
module tb_duty_breathe;

   localparam int P    = 10;
   localparam int FPS  = 2;
   localparam int STEP = 64;
   localparam int HOLD = 3;
   localparam int MAN  = 16;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   // Reference model: elapsed cycles since reset, frame-level duty/state bookkeeping.
   int   m_cycles;
   int   m_duty;
   int   m_state;
   int   m_ticks;
   bit   m_pinc;
   bit   m_pdec;
   bit   m_seen;
   int   prev_duty;
   bit   wrap_edge;

   duty_breathe_if bus ();

   duty_breathe #(
      .PERIOD_CYCLES  (P),
      .FRAMES_PER_STEP(FPS),
      .STEP           (STEP),
      .HOLD_FRAMES    (HOLD),
      .MAN_STEP       (MAN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int expected);
      checks++;
      if (got == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expected);
   endtask

   task automatic model_reset();
      m_cycles  = 0;
      m_duty    = 0;
      m_state   = 0;
      m_ticks   = 0;
      m_pinc    = 0;
      m_pdec    = 0;
      m_seen    = 0;
      prev_duty = 0;
   endtask

   task automatic model_step(input bit en, input bit mode, input bit inc, input bit dec);
      bit upd;
      wrap_edge = (m_cycles % P) == (P - 1);
      upd = wrap_edge && en;
      if (upd && mode) begin
         if (m_seen) begin
            m_state = 0;
            m_ticks = 0;
            m_seen  = 0;
         end else begin
            m_ticks++;
            case (m_state)
               0: if (m_ticks % FPS == 0) begin
                     if (m_duty + STEP >= 255) begin
                        m_duty = 255; m_state = 1; m_ticks = 0;
                     end else m_duty = m_duty + STEP;
                  end
               1: if (m_ticks == HOLD) begin m_state = 2; m_ticks = 0; end
               2: if (m_ticks % FPS == 0) begin
                     if (m_duty <= STEP) begin
                        m_duty = 0; m_state = 3; m_ticks = 0;
                     end else m_duty = m_duty - STEP;
                  end
               default: if (m_ticks == HOLD) begin m_state = 0; m_ticks = 0; end
            endcase
         end
      end else if (upd) begin
         if (m_pinc && !m_pdec)      m_duty = (m_duty + MAN > 255) ? 255 : m_duty + MAN;
         else if (m_pdec && !m_pinc) m_duty = (m_duty < MAN) ? 0 : m_duty - MAN;
      end
      if (mode) begin
         m_pinc = 0; m_pdec = 0;
      end else if (upd) begin
         m_pinc = inc; m_pdec = dec;
      end else begin
         m_pinc = m_pinc | inc; m_pdec = m_pdec | dec;
      end
      if (!mode) m_seen = 1;
      m_cycles++;
   endtask

   // One clock: drive inputs, advance the model, then compare just after the edge.
   task automatic applyStimulus(input bit en, input bit mode, input bit inc, input bit dec);
      bus.en   = en;
      bus.mode = mode;
      bus.inc  = inc;
      bus.dec  = dec;
      model_step(en, mode, inc, dec);
      @(posedge clk);
      #1;
      checkOutput("duty", bus.duty, m_duty);
      checkOutput("frame_tick", bus.frame_tick, ((m_cycles % P) == (P - 1)) ? 1 : 0);
      checkOutput("state", bus.state, m_state);
      if (int'(bus.duty) != prev_duty) checkOutput("duty_only_at_wrap", wrap_edge, 1);
      prev_duty = bus.duty;
   endtask

   task automatic run_frames(input int n, input bit en, input bit mode);
      repeat (n * P) applyStimulus(en, mode, 1'b0, 1'b0);
   endtask

   // One manual frame with an inc and/or dec pulse at the given in-frame cycle.
   task automatic man_frame(input int at, input bit inc, input bit dec);
      for (int c = 0; c < P; c++) applyStimulus(1'b1, 1'b0, (c == at) && inc, (c == at) && dec);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_duty", bus.duty, 0);
      checkOutput("rst_tick", bus.frame_tick, 0);
      checkOutput("rst_state", bus.state, 0);
      model_reset();
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      int fr[11];
      int ed[11];
      int es[11];
      int done;
      bit r_en;
      bit r_mode;
      checks   = 0;
      passes   = 0;
      rst      = 1'b0;
      bus.en   = 1'b0;
      bus.mode = 1'b0;
      bus.inc  = 1'b0;
      bus.dec  = 1'b0;
      model_reset();
      #3;
      checkOutput("init_duty", bus.duty, 0);
      checkOutput("init_state", bus.state, 0);
      @(posedge clk);
      #2 rst = 1'b1;

      // Mid-ramp reset restarts from zero with ticks every P cycles.
      run_frames(5, 1'b1, 1'b1);
      bus.mode = 1'b1;
      do_reset();
      run_frames(2, 1'b1, 1'b1);

      // Full breathing cycle from reset.
      do_reset();
      fr = '{2, 4, 6, 8, 11, 13, 15, 17, 19, 22, 24};
      ed = '{64, 128, 192, 255, 255, 191, 127, 63, 0, 0, 64};
      es = '{0, 0, 0, 1, 2, 2, 2, 2, 3, 0, 0};
      done = 0;
      for (int i = 0; i < 11; i++) begin
         run_frames(fr[i] - done, 1'b1, 1'b1);
         done = fr[i];
         checkOutput("breathe_duty", bus.duty, ed[i]);
         checkOutput("breathe_state", bus.state, es[i]);
      end

      // Manual: repeated incs in one frame count once, saturation, floor.
      bus.mode = 1'b0;
      do_reset();
      for (int c = 0; c < P; c++) applyStimulus(1'b1, 1'b0, (c == 1) || (c == 3) || (c == 5), 1'b0);
      checkOutput("man_inc_once", bus.duty, 16);
      repeat (17) man_frame(0, 1'b1, 1'b0);
      checkOutput("man_sat_hi", bus.duty, 255);
      repeat (16) man_frame(0, 1'b0, 1'b1);
      checkOutput("man_floor", bus.duty, 0);
      man_frame(P - 1, 1'b1, 1'b0);
      checkOutput("inc_on_update_edge_deferred", bus.duty, 0);
      man_frame(5, 1'b0, 1'b0);
      checkOutput("inc_on_update_edge_applied", bus.duty, 16);

      // Manual: inc and dec in the same frame cancel.
      for (int c = 0; c < P; c++) applyStimulus(1'b1, 1'b0, c == 2, c == 6);
      checkOutput("inc_dec_cancel", bus.duty, 16);
      man_frame(0, 1'b0, 1'b0);
      checkOutput("flags_cleared", bus.duty, 16);

      // Enable low freezes the ramp at 128.
      bus.mode = 1'b1;
      do_reset();
      run_frames(4, 1'b1, 1'b1);
      checkOutput("freeze_start", bus.duty, 128);
      for (int f = 0; f < 5; f++) begin
         run_frames(1, 1'b0, 1'b1);
         checkOutput("frozen_duty", bus.duty, 128);
      end
      run_frames(2, 1'b1, 1'b1);
      checkOutput("resume_duty", bus.duty, 192);

      // Randomized mix of enables, mode swaps and button pulses.
      r_en   = 1'b1;
      r_mode = 1'b1;
      for (int n = 0; n < 6000; n++) begin
         if ($urandom_range(0, 59) == 0) r_en = ~r_en;
         if ($urandom_range(0, 299) == 0) r_mode = ~r_mode;
         applyStimulus(r_en, r_mode, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
         if (n == 3000) begin
            bus.mode = r_mode;
            do_reset();
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
